// File: rtl/instr_queue_pkg.sv
// Shared CPU word widths for the instruction queue.
package instr_queue_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

endpackage

// File: rtl/instr_queue.sv
// Circular show-ahead instruction queue between fetch and the ROB; write-to-issue latency 1 cycle (0 with IQ_BYPASS_EN on an empty queue).
// Backpressure: iq_full_out stalls fetch from registered count only; rob_full_in holds issue; rdy_in low freezes all state.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_valid_in,
  input  logic [INST_W-1:0] if_inst_in,
  input  logic [PC_W-1:0]   if_pc_in,
  output logic              iq_full_out,
  input  logic              rob_full_in,
  input  logic              rob_flush_in,
  output logic              issue_valid_out,
  output logic [INST_W-1:0] issue_inst_out,
  output logic [PC_W-1:0]   issue_pc_out
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W:0]    count_q;

  logic              not_empty;
  logic              byp_vld;
  logic              enq_fire;
  logic              iss_fire;

  assign not_empty   = (count_q != '0);
  assign iq_full_out = (count_q == FULL_CNT);

`ifdef IQ_BYPASS_EN
  // Empty queue and a ROB that can accept: hand the fetched word straight through.
  assign byp_vld = rdy_in && if_valid_in && !not_empty && !rob_full_in && !rob_flush_in;
`else
  assign byp_vld = 1'b0;
`endif

  // Full is checked on registered count, so a same-cycle issue never frees a slot early.
  assign enq_fire = rdy_in && if_valid_in && !iq_full_out && !byp_vld;
  assign iss_fire = rdy_in && not_empty && !rob_full_in;

  always_comb begin
    issue_valid_out = not_empty && !rob_flush_in;
    issue_inst_out  = inst_mem[head_q];
    issue_pc_out    = pc_mem[head_q];
    if (byp_vld) begin
      issue_valid_out = 1'b1;
      issue_inst_out  = if_inst_in;
      issue_pc_out    = if_pc_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (rob_flush_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (enq_fire) tail_q <= tail_q + PTR_ONE;
        if (iss_fire) head_q <= head_q + PTR_ONE;
        case ({enq_fire, iss_fire})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage carries no reset; validity is tracked solely by count/pointers.
  always_ff @(posedge clk_in) begin
    if (enq_fire && !rob_flush_in) begin
      inst_mem[tail_q] <= if_inst_in;
      pc_mem[tail_q]   <= if_pc_in;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH 16), both with and without IQ_BYPASS_EN.
module tb_instr_queue;

  localparam int DEPTH = 16;
`ifdef IQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_valid_in;
  logic [31:0] if_inst_in;
  logic [31:0] if_pc_in;
  logic        iq_full_out;
  logic        rob_full_in;
  logic        rob_flush_in;
  logic        issue_valid_out;
  logic [31:0] issue_inst_out;
  logic [31:0] issue_pc_out;

  int n_chk  = 0;
  int n_fail = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .if_valid_in     (if_valid_in),
    .if_inst_in      (if_inst_in),
    .if_pc_in        (if_pc_in),
    .iq_full_out     (iq_full_out),
    .rob_full_in     (rob_full_in),
    .rob_flush_in    (rob_flush_in),
    .issue_valid_out (issue_valid_out),
    .issue_inst_out  (issue_inst_out),
    .issue_pc_out    (issue_pc_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    if_valid_in = 1'b1;
    if_inst_in  = inst;
    if_pc_in    = pc;
    tick();
    if_valid_in = 1'b0;
  endtask

  initial begin
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    if_valid_in  = 1'b0;
    if_inst_in   = '0;
    if_pc_in     = '0;
    rob_full_in  = 1'b0;
    rob_flush_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    settle();
    chk("reset_full", iq_full_out, 0);
    chk("reset_valid", issue_valid_out, 0);

    // Two words in program order, ROB ready.
    if_valid_in = 1'b1; if_inst_in = 32'h0000_0013; if_pc_in = 32'h0;
    settle();
    chk("t1_a_valid", issue_valid_out, BYP);
`ifdef IQ_BYPASS_EN
    chk("t1_a_byp_inst", issue_inst_out, 32'h0000_0013);
    chk("t1_a_byp_pc", issue_pc_out, 32'h0);
`endif
    tick();
    if_inst_in = 32'h0010_0093; if_pc_in = 32'h4;
    settle();
    chk("t1_b_valid", issue_valid_out, 1);
    chk("t1_b_inst", issue_inst_out, BYP ? 32'h0010_0093 : 32'h0000_0013);
    chk("t1_b_pc", issue_pc_out, BYP ? 32'h4 : 32'h0);
    tick();
    if_valid_in = 1'b0;
    settle();
    chk("t1_c_valid", issue_valid_out, !BYP);
`ifndef IQ_BYPASS_EN
    chk("t1_c_inst", issue_inst_out, 32'h0010_0093);
    chk("t1_c_pc", issue_pc_out, 32'h4);
`endif
    tick();
    chk("t1_d_valid", issue_valid_out, 0);
    chk("t1_d_full", iq_full_out, 0);

    // Fill to DEPTH with the ROB blocked.
    rob_full_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t2_not_full_at_15", iq_full_out, 0);
      push(32'h1000 + i, 32'h100 + 4 * i);
    end
    chk("t2_full", iq_full_out, 1);
    chk("t2_head_inst", issue_inst_out, 32'h1000);
    push(32'hDEAD_0000, 32'hDEAD);
    chk("t2_still_full", iq_full_out, 1);
    chk("t2_head_kept", issue_inst_out, 32'h1000);

    // Full with a same-cycle issue: the new word must still be rejected.
    rob_full_in = 1'b0;
    if_valid_in = 1'b1; if_inst_in = 32'hBEEF_0000; if_pc_in = 32'hBEEF;
    settle();
    chk("t3_issue_inst", issue_inst_out, 32'h1000);
    tick();
    if_valid_in = 1'b0;
    rob_full_in = 1'b1;
    settle();
    chk("t3_count15_not_full", iq_full_out, 0);
    chk("t3_head_next", issue_inst_out, 32'h1001);
    tick();
    rob_full_in = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      settle();
      chk($sformatf("t3_drain_valid%0d", i), issue_valid_out, 1);
      chk($sformatf("t3_drain_inst%0d", i), issue_inst_out, 32'h1000 + i);
      chk($sformatf("t3_drain_pc%0d", i), issue_pc_out, 32'h100 + 4 * i);
      tick();
    end
    chk("t3_empty", issue_valid_out, 0);

    // Advance the pointers so the next batch wraps the ring.
    rob_full_in = 1'b1;
    for (int i = 0; i < 12; i++) push(32'h2000 + i, 32'h200 + 4 * i);
    rob_full_in = 1'b0;
    repeat (12) tick();
    chk("t4_pre_empty", issue_valid_out, 0);

    rob_full_in = 1'b1;
    for (int i = 0; i < 10; i++) push(32'h3000 + i, 4 * i);
    rob_full_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("t4_wrap_inst%0d", i), issue_inst_out, 32'h3000 + i);
      chk($sformatf("t4_wrap_pc%0d", i), issue_pc_out, 4 * i);
      tick();
    end
    chk("t4_empty", issue_valid_out, 0);

    // Flush with five held entries and a fetch in the same cycle.
    rob_full_in = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h4000 + i, 32'h400 + 4 * i);
    chk("t5_held_valid", issue_valid_out, 1);
    rob_full_in  = 1'b0;
    rob_flush_in = 1'b1;
    if_valid_in  = 1'b1; if_inst_in = 32'hF00D_0000; if_pc_in = 32'hF00D;
    settle();
    chk("t5_flush_valid_low", issue_valid_out, 0);
    tick();
    rob_flush_in = 1'b0;
    if_valid_in  = 1'b0;
    settle();
    chk("t5_after_valid", issue_valid_out, 0);
    chk("t5_after_full", iq_full_out, 0);
    rob_full_in = 1'b1;
    push(32'h5000, 32'h500);
    chk("t5_fresh_inst", issue_inst_out, 32'h5000);
    chk("t5_fresh_pc", issue_pc_out, 32'h500);

    // Stall with traffic: nothing enqueued or issued.
    rob_full_in = 1'b0;
    rdy_in      = 1'b0;
    if_valid_in = 1'b1; if_inst_in = 32'h6000_0000; if_pc_in = 32'h600;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t6_stall_valid%0d", i), issue_valid_out, 1);
      chk($sformatf("t6_stall_inst%0d", i), issue_inst_out, 32'h5000);
      tick();
    end
    rdy_in      = 1'b1;
    if_valid_in = 1'b0;
    settle();
    chk("t6_resume_inst", issue_inst_out, 32'h5000);
    tick();
    chk("t6_resume_empty", issue_valid_out, 0);

    // Reset mid-operation overrides a low rdy_in.
    rob_full_in = 1'b1;
    push(32'h7000, 32'h700);
    push(32'h7001, 32'h704);
    rdy_in = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    settle();
    chk("t7_rst_valid", issue_valid_out, 0);
    chk("t7_rst_full", iq_full_out, 0);

    // Empty queue with ROB full: stored normally in either build.
    if_valid_in = 1'b1; if_inst_in = 32'h8000; if_pc_in = 32'h800;
    settle();
    chk("t8_robfull_same_cycle", issue_valid_out, 0);
    tick();
    if_valid_in = 1'b0;
    settle();
    chk("t8_robfull_stored_valid", issue_valid_out, 1);
    chk("t8_robfull_stored_inst", issue_inst_out, 32'h8000);
    rob_full_in = 1'b0;
    tick();
    chk("t8_drained", issue_valid_out, 0);

    // Empty queue, ROB ready: bypass only when enabled.
    if_valid_in = 1'b1; if_inst_in = 32'hCAFE; if_pc_in = 32'h900;
    settle();
    chk("t9_same_cycle_valid", issue_valid_out, BYP);
`ifdef IQ_BYPASS_EN
    chk("t9_byp_inst", issue_inst_out, 32'hCAFE);
    chk("t9_byp_pc", issue_pc_out, 32'h900);
`endif
    tick();
    if_valid_in = 1'b0;
    settle();
    chk("t9_next_valid", issue_valid_out, !BYP);
`ifndef IQ_BYPASS_EN
    chk("t9_next_inst", issue_inst_out, 32'hCAFE);
`endif
    tick();
    chk("t9_final_empty", issue_valid_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
